// File: rtl/timer_multi_pkg.sv
// Shared definitions for the multi-channel timer: bus handshake levels,
// register offsets, CTRL field positions and count-mode encodings.
package timer_multi_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic READ    = 1'b1;
  localparam logic WRITE   = 1'b0;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_EXPR   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_MODE_LSB   = 1;
  localparam int unsigned CTRL_IE_BIT     = 3;
  localparam int unsigned CTRL_PSC_LSB    = 8;
  localparam int unsigned STATUS_FLAG_BIT = 0;

  typedef enum logic [1:0] {
    TM_ONESHOT_UP   = 2'b00,
    TM_CIRCLE_UP    = 2'b01,
    TM_CIRCLE_DOWN  = 2'b10,
    TM_ONESHOT_DOWN = 2'b11
  } tm_mode_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  function automatic logic mode_is_up(input tm_mode_e m);
    return (m == TM_ONESHOT_UP) || (m == TM_CIRCLE_UP);
  endfunction

  function automatic logic mode_is_circ(input tm_mode_e m);
    return (m == TM_CIRCLE_UP) || (m == TM_CIRCLE_DOWN);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/EXPR/COUNT/flag registers, prescaler and the
// idle/run count FSM. Register writes arrive as per-register strobes.
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PSC_W  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ctrl_we_i,
  input  logic              expr_we_i,
  input  logic              count_we_i,
  input  logic              status_we_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] expr_o,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] status_o,
  output logic              irq_o
);

  ch_state_e        state_q, state_d;
  tm_mode_e         mode_q, mode_d;
  logic             ie_q, ie_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] expr_q, expr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  logic     running;
  logic     tick;
  logic     wr_start;
  tm_mode_e wr_mode;
  logic     stop_wr;
  logic     do_tick;
  logic     at_limit;

  assign running  = (state_q == CH_RUN);
  assign wr_start = wr_data_i[CTRL_START_BIT];
  assign wr_mode  = tm_mode_e'(wr_data_i[CTRL_MODE_LSB +: 2]);
  assign stop_wr  = ctrl_we_i && !wr_start;
  // >= rather than == so a psc lowered mid-count cannot strand psc_cnt above it
  assign tick     = running && (psc_cnt_q >= psc_q);
  assign do_tick  = tick && !stop_wr && !count_we_i;
  assign at_limit = mode_is_up(mode_q) ? (count_q == expr_q) : (count_q == '0);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ie_d      = ie_q;
    psc_d     = psc_q;
    psc_cnt_d = psc_cnt_q;
    expr_d    = expr_q;
    count_d   = count_q;
    flag_d    = flag_q;

    if (ctrl_we_i) begin
      mode_d  = wr_mode;
      ie_d    = wr_data_i[CTRL_IE_BIT];
      psc_d   = wr_data_i[CTRL_PSC_LSB +: PSC_W];
      state_d = wr_start ? CH_RUN : CH_IDLE;
      if (wr_start && !running)
        count_d = mode_is_up(wr_mode) ? '0 : expr_q;
    end

    if (expr_we_i)
      expr_d = wr_data_i[CNT_W-1:0];

    if (count_we_i) begin
      count_d = wr_data_i[CNT_W-1:0];
    end else if (do_tick) begin
      if (at_limit) begin
        if (mode_is_circ(mode_q))
          count_d = mode_is_up(mode_q) ? '0 : expr_q;
        else
          state_d = CH_IDLE;
      end else begin
        count_d = mode_is_up(mode_q) ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      end
    end

    if (!running || stop_wr || tick)
      psc_cnt_d = '0;
    else
      psc_cnt_d = psc_cnt_q + PSC_W'(1);

    // expiry is applied after the clear so a coincident set wins
    if (status_we_i && wr_data_i[STATUS_FLAG_BIT])
      flag_d = 1'b0;
    if (do_tick && at_limit)
      flag_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CH_IDLE;
      mode_q    <= TM_ONESHOT_UP;
      ie_q      <= 1'b0;
      psc_q     <= '0;
      psc_cnt_q <= '0;
      expr_q    <= '0;
      count_q   <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ie_q      <= ie_d;
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
      expr_q    <= expr_d;
      count_q   <= count_d;
      flag_q    <= flag_d;
    end
  end

  assign ctrl_o   = DATA_W'({psc_q, 4'b0000, ie_q, mode_q, running});
  assign expr_o   = DATA_W'(expr_q);
  assign count_o  = DATA_W'(count_q);
  assign status_o = DATA_W'(flag_q);
  assign irq_o    = flag_q && ie_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel bus timer: address decode, registered read path with a
// one-cycle rdy pulse per access, and OR-reduced channel interrupts.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PSC_W  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              tm_cs,
  input  logic              tm_as,
  input  logic              tm_rw,
  input  logic [ADDR_W-1:0] tm_addr,
  input  logic [DATA_W-1:0] tm_wr_data,
  output logic              tm_rdy,
  output logic [DATA_W-1:0] tm_rd_data,
  output logic              tm_irq
);

  localparam int unsigned CH_W = ADDR_W - 2;

  logic              access;
  logic              wr_acc;
  logic              rd_acc;
  logic [CH_W-1:0]   ch_idx;
  logic [1:0]        reg_off;
  logic [NUM_CH-1:0] ch_irq;
  logic [DATA_W-1:0] ch_rd [NUM_CH];
  logic [DATA_W-1:0] rd_mux;

  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  assign access  = (tm_cs == ENABLE) && (tm_as == ENABLE);
  assign wr_acc  = access && (tm_rw == WRITE);
  assign rd_acc  = access && (tm_rw == READ);
  assign ch_idx  = tm_addr[ADDR_W-1:2];
  assign reg_off = tm_addr[1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic              sel;
    logic [DATA_W-1:0] ctrl_w, expr_w, count_w, status_w;

    assign sel = wr_acc && (ch_idx == CH_W'(i));

    timer_channel #(
      .CNT_W (CNT_W),
      .PSC_W (PSC_W),
      .DATA_W(DATA_W)
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (rest),
      .ctrl_we_i  (sel && (reg_off == REG_CTRL)),
      .expr_we_i  (sel && (reg_off == REG_EXPR)),
      .count_we_i (sel && (reg_off == REG_COUNT)),
      .status_we_i(sel && (reg_off == REG_STATUS)),
      .wr_data_i  (tm_wr_data),
      .ctrl_o     (ctrl_w),
      .expr_o     (expr_w),
      .count_o    (count_w),
      .status_o   (status_w),
      .irq_o      (ch_irq[i])
    );

    assign ch_rd[i] = (reg_off == REG_CTRL)  ? ctrl_w  :
                      (reg_off == REG_EXPR)  ? expr_w  :
                      (reg_off == REG_COUNT) ? count_w : status_w;
  end

  // indices at or above NUM_CH match no channel and read back as zero
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i))
        rd_mux = ch_rd[i];
    end
  end

  always_comb begin
    rdy_d     = access;
    rd_data_d = rd_acc ? rd_mux : '0;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      rdy_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign tm_rdy     = rdy_q;
  assign tm_rd_data = rd_data_q;
  assign tm_irq     = |ch_irq;

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: each bus access queues its expected
// read data; a negedge monitor pops and compares whenever tm_rdy is high.
module tb_timer_multi;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic        clk;
  logic        rest;
  logic        tm_cs;
  logic        tm_as;
  logic        tm_rw;
  logic [4:0]  tm_addr;
  logic [31:0] tm_wr_data;
  logic        tm_rdy;
  logic [31:0] tm_rd_data;
  logic        tm_irq;

  int n_pass  = 0;
  int n_total = 0;
  int acc_id  = 0;

  typedef struct {
    int          id;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  timer_multi #(
    .NUM_CH(4),
    .CNT_W (32),
    .DATA_W(32),
    .PSC_W (8),
    .ADDR_W(5)
  ) dut (
    .clk       (clk),
    .rest      (rest),
    .tm_cs     (tm_cs),
    .tm_as     (tm_as),
    .tm_rw     (tm_rw),
    .tm_addr   (tm_addr),
    .tm_wr_data(tm_wr_data),
    .tm_rdy    (tm_rdy),
    .tm_rd_data(tm_rd_data),
    .tm_irq    (tm_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (tm_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rdy_without_access", 32'd1, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        chk($sformatf("rd_data[acc%0d]", e.id), tm_rd_data, e.exp);
      end
    end
  end

  // Drive one access at a negedge; return just after the sampling posedge.
  task automatic acc(input logic rw, input int ch, input int off,
                     input logic [31:0] wdata, input logic [31:0] exp,
                     input bit push = 1'b1);
    @(negedge clk);
    tm_cs      = 1'b1;
    tm_as      = 1'b1;
    tm_rw      = rw;
    tm_addr    = 5'((ch << 2) | off);
    tm_wr_data = wdata;
    if (push) begin
      sb.push_back('{id: acc_id, exp: exp});
      acc_id++;
    end
    @(posedge clk);
    #1;
    tm_cs = 1'b0;
    tm_as = 1'b0;
  endtask

  task automatic wr(input int ch, input int off, input logic [31:0] d);
    acc(WR, ch, off, d, 32'd0);
  endtask

  task automatic rd(input int ch, input int off, input logic [31:0] exp);
    acc(RD, ch, off, 32'd0, exp);
  endtask

  initial begin
    int exp_seq_ch1 [13] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0};

    rest       = 1'b0;
    tm_cs      = 1'b0;
    tm_as      = 1'b0;
    tm_rw      = RD;
    tm_addr    = '0;
    tm_wr_data = '0;
    #2;
    chk("reset_rdy", 32'(tm_rdy), 32'd0);
    chk("reset_rd_data", tm_rd_data, 32'd0);
    chk("reset_irq", 32'(tm_irq), 32'd0);
    repeat (2) @(negedge clk);
    rest = 1'b1;

    // all registers of every channel read zero after reset
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 4; o++)
        rd(c, o, 32'd0);
    rd(7, 2, 32'd0);
    wr(4, 2, 32'h77);
    wr(5, 0, 32'h1);
    rd(0, 2, 32'd0);
    rd(1, 0, 32'd0);
    chk("irq_after_reset", 32'(tm_irq), 32'd0);

    // ch0 circular up, EXPR=5, psc=0, ie
    wr(0, 1, 32'd5);
    wr(0, 0, 32'h0000_000B);
    for (int k = 2; k <= 12; k++)
      rd(0, 2, 32'((k - 2) % 6));
    wr(0, 0, 32'h0000_000A);
    rd(0, 2, 32'd5);
    rd(0, 0, 32'h0000_000A);
    rd(0, 3, 32'd1);
    chk("ch0_irq_set", 32'(tm_irq), 32'd1);
    wr(0, 3, 32'd1);
    chk("ch0_irq_cleared", 32'(tm_irq), 32'd0);
    rd(0, 3, 32'd0);

    // ch1 one-shot down, EXPR=3, psc=2
    wr(1, 1, 32'd3);
    wr(1, 0, 32'h0000_0207);
    for (int k = 0; k < 13; k++)
      rd(1, 2, 32'(exp_seq_ch1[k]));
    rd(1, 0, 32'h0000_0206);
    rd(1, 3, 32'd1);
    chk("ch1_irq_masked", 32'(tm_irq), 32'd0);
    rd(1, 2, 32'd0);

    // ch2 circular down (no ie) with ch3 one-shot up (ie)
    wr(2, 1, 32'd4);
    wr(3, 1, 32'd2);
    wr(2, 0, 32'h0000_0005);
    wr(3, 0, 32'h0000_0009);
    chk("ch23_irq_idle", 32'(tm_irq), 32'd0);
    rd(3, 2, 32'd0);
    rd(2, 2, 32'd2);
    rd(3, 3, 32'd0);
    chk("ch3_irq_set", 32'(tm_irq), 32'd1);
    rd(2, 3, 32'd0);
    rd(2, 3, 32'd1);
    rd(2, 2, 32'd3);
    rd(3, 2, 32'd2);
    rd(3, 0, 32'h0000_0008);
    chk("ch3_irq_held", 32'(tm_irq), 32'd1);
    wr(3, 3, 32'd1);
    chk("ch2_flag_masked", 32'(tm_irq), 32'd0);
    wr(2, 0, 32'h0000_0000);
    rd(2, 3, 32'd1);

    // ch0: COUNT write on an expiring tick, then set coincident with W1C
    wr(0, 0, 32'h0000_000B);
    for (int k = 1; k <= 5; k++)
      rd(0, 2, 32'(k - 1));
    wr(0, 2, 32'd2);
    rd(0, 2, 32'd2);
    rd(0, 3, 32'd0);
    rd(0, 2, 32'd4);
    wr(0, 3, 32'd1);
    rd(0, 3, 32'd1);
    chk("set_beats_w1c_irq", 32'(tm_irq), 32'd1);
    rd(0, 2, 32'd1);
    wr(0, 0, 32'h0000_0000);
    wr(0, 3, 32'd1);
    chk("ch0_stop_clear_irq", 32'(tm_irq), 32'd0);
    rd(0, 3, 32'd0);

    // asynchronous reset while ch0 and ch1 run
    wr(0, 0, 32'h0000_000B);
    wr(1, 0, 32'h0000_0207);
    for (int k = 2; k <= 6; k++)
      rd(0, 2, 32'(k - 1));
    acc(RD, 0, 2, 32'd0, 32'd0, 1'b0);
    chk("pre_reset_rdy", 32'(tm_rdy), 32'd1);
    chk("pre_reset_irq", 32'(tm_irq), 32'd1);
    #1;
    rest = 1'b0;
    #1;
    chk("midrun_reset_rdy", 32'(tm_rdy), 32'd0);
    chk("midrun_reset_rd_data", tm_rd_data, 32'd0);
    chk("midrun_reset_irq", 32'(tm_irq), 32'd0);
    repeat (2) @(negedge clk);
    rest = 1'b1;
    rd(0, 0, 32'd0);
    rd(0, 1, 32'd0);
    rd(0, 2, 32'd0);
    rd(0, 3, 32'd0);
    rd(1, 0, 32'd0);
    rd(1, 2, 32'd0);
    repeat (5) @(posedge clk);
    rd(0, 2, 32'd0);
    rd(1, 2, 32'd0);
    chk("post_reset_irq", 32'(tm_irq), 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
